// File: rtl/chan_scan_mux.sv
// chan_scan_mux: registered N-channel W-bit multiplexer with a manual/auto-scan
// sequencer. Each sample is delivered on a valid/ready output and held until accepted.
module chan_scan_mux #(
  parameter int WIDTH = 4,
  parameter int NCH   = 8,
  parameter int SELW  = $clog2(NCH),
  parameter int DWELL = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  input  logic [NCH*WIDTH-1:0] in_data,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_ch,
  output logic                 out_err,
  output logic                 out_valid,
  input  logic                 out_ready
);

  // Dwell counter only ever holds DWELL-1 down to 0; keep at least one bit.
  localparam int CNTW = (DWELL > 1) ? $clog2(DWELL) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAPTURE,
    S_WAIT_ACK,
    S_DWELL
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [SELW-1:0]   scan_ptr;
  logic [CNTW-1:0]   dwell_cnt;
  logic [SELW-1:0]   cap_ch;
  logic [WIDTH-1:0]  cap_data;
  logic              cap_err;
  logic              accept;

  // A sample is outstanding exactly while waiting for the consumer.
  assign out_valid = (state == S_WAIT_ACK);
  assign accept    = (state == S_WAIT_ACK) && out_ready;

  // State register; reset discards any pending sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Sequencer: capture, wait for handshake, optional dwell gap in scan mode.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (en) next_state = S_CAPTURE;
      end
      S_CAPTURE: begin
        next_state = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (out_ready) begin
          if (!en)                      next_state = S_IDLE;
          else if (mode && (DWELL > 0)) next_state = S_DWELL;
          else                          next_state = S_CAPTURE;
        end
      end
      S_DWELL: begin
        if (!en)                   next_state = S_IDLE;
        else if (dwell_cnt == '0)  next_state = S_CAPTURE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Channel selection; an out-of-range manual select yields a flagged zero sample.
  always_comb begin
    cap_ch   = mode ? scan_ptr : sel;
    cap_data = '0;
    cap_err  = 1'b0;
    if (int'(cap_ch) >= NCH) begin
      cap_err = 1'b1;
    end else begin
      cap_data = in_data[int'(cap_ch)*WIDTH +: WIDTH];
    end
  end

  // Output sample registers, scan pointer and dwell counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data  <= '0;
      out_ch    <= '0;
      out_err   <= 1'b0;
      scan_ptr  <= '0;
      dwell_cnt <= '0;
    end else begin
      if (state == S_CAPTURE) begin
        out_data <= cap_data;
        out_ch   <= cap_ch;
        out_err  <= cap_err;
      end
      if (accept && mode) begin
        scan_ptr <= (scan_ptr == SELW'(NCH-1)) ? '0 : scan_ptr + 1'b1;
      end
      if (accept && (next_state == S_DWELL)) begin
        dwell_cnt <= CNTW'(DWELL-1);
      end else if ((state == S_DWELL) && (dwell_cnt != '0)) begin
        dwell_cnt <= dwell_cnt - 1'b1;
      end
    end
  end

endmodule
